sdram_read_arbiter: RTL and testbench

Shares the single SDRAM read port between two requesters. The video controller (character/attribute row preload, priority) is one; an auxiliary reader is the other (e.g. the terminal/CPU side reading page memory). Each requester issues single-cycle burst requests, which are latched, arbitrated and replayed to the SDRAM controller one burst at a time. Returned beats are steered back to the granted requester with zero added latency. The block sits between video_controller, the aux reader and the SDRAM controller read interface.

---
 rtl/sdram_read_arbiter.sv | 145 ++++++++++++++
 tb/tb_sdram_read_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_read_arbiter.sv
// Two-requester arbiter for the SDRAM read port: latches single-cycle burst requests,
// replays them one at a time (video first) and steers returned beats to the owner.
module sdram_read_arbiter #(
    parameter int ADDR_WIDTH  = 23,
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_WIDTH = 9,
    parameter int TIMEOUT     = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vid_rd_request,
    input  logic [ADDR_WIDTH-1:0]  vid_rd_address,
    input  logic [BURST_WIDTH-1:0] vid_rd_burst_length,
    output logic                   vid_rd_available,
    output logic [DATA_WIDTH-1:0]  vid_rd_data,
    input  logic                   aux_rd_request,
    input  logic [ADDR_WIDTH-1:0]  aux_rd_address,
    input  logic [BURST_WIDTH-1:0] aux_rd_burst_length,
    output logic                   aux_rd_available,
    output logic [DATA_WIDTH-1:0]  aux_rd_data,
    output logic                   mem_rd_request,
    output logic [ADDR_WIDTH-1:0]  mem_rd_address,
    output logic [BURST_WIDTH-1:0] mem_rd_burst_length,
    input  logic                   mem_rd_available,
    input  logic [DATA_WIDTH-1:0]  mem_rd_data,
    output logic                   busy,
    output logic                   grant_aux,
    output logic [1:0]             overrun,
    output logic                   timeout,
    output logic [1:0]             o_dbg_state
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_XFER  = 2'd2
    } state_t;

    state_t                 r_state, w_next;
    logic                   r_vid_pend, r_aux_pend;
    logic [ADDR_WIDTH-1:0]  r_vid_addr, r_aux_addr;
    logic [BURST_WIDTH-1:0] r_vid_len, r_aux_len;
    logic                   r_grant_aux;
    logic [BURST_WIDTH-1:0] r_beat_cnt;
    logic [TO_W-1:0]        r_to_cnt;
    logic [1:0]             r_overrun;
    logic                   r_timeout;

    logic                   w_busy, w_xfer, w_vid_drop, w_aux_drop;
    logic                   w_last_beat, w_to_hit;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [BURST_WIDTH-1:0] w_sel_len;

    assign w_busy     = (r_state != S_IDLE);
    assign w_xfer     = (r_state == S_XFER);
    // A requester cannot queue behind its own in-flight burst: only one slot each.
    assign w_vid_drop = r_vid_pend | (w_busy & ~r_grant_aux);
    assign w_aux_drop = r_aux_pend | (w_busy & r_grant_aux);
    assign w_sel_addr = r_grant_aux ? r_aux_addr : r_vid_addr;
    assign w_sel_len  = r_grant_aux ? r_aux_len : r_vid_len;

    assign w_last_beat = w_xfer & mem_rd_available & (r_beat_cnt == BURST_WIDTH'(1));
    assign w_to_hit    = w_xfer & ~mem_rd_available & (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_vid_pend || r_aux_pend) w_next = S_ISSUE;
            S_ISSUE: w_next = (w_sel_len == '0) ? S_IDLE : S_XFER;
            S_XFER:  if (w_last_beat || w_to_hit) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_vid_pend  <= 1'b0;
            r_aux_pend  <= 1'b0;
            r_vid_addr  <= '0;
            r_aux_addr  <= '0;
            r_vid_len   <= '0;
            r_aux_len   <= '0;
            r_grant_aux <= 1'b0;
            r_beat_cnt  <= '0;
            r_to_cnt    <= '0;
            r_overrun   <= 2'b00;
            r_timeout   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_overrun <= {aux_rd_request & w_aux_drop, vid_rd_request & w_vid_drop};
            r_timeout <= w_to_hit;

            if (vid_rd_request && !w_vid_drop) begin
                r_vid_pend <= 1'b1;
                r_vid_addr <= vid_rd_address;
                r_vid_len  <= vid_rd_burst_length;
            end else if (r_state == S_ISSUE && !r_grant_aux) begin
                r_vid_pend <= 1'b0;
            end

            if (aux_rd_request && !w_aux_drop) begin
                r_aux_pend <= 1'b1;
                r_aux_addr <= aux_rd_address;
                r_aux_len  <= aux_rd_burst_length;
            end else if (r_state == S_ISSUE && r_grant_aux) begin
                r_aux_pend <= 1'b0;
            end

            if (r_state == S_IDLE) begin
                if (r_vid_pend)      r_grant_aux <= 1'b0;
                else if (r_aux_pend) r_grant_aux <= 1'b1;
            end

            if (r_state == S_ISSUE) begin
                r_beat_cnt <= w_sel_len;
                r_to_cnt   <= '0;
            end else if (w_xfer) begin
                if (mem_rd_available) begin
                    r_beat_cnt <= r_beat_cnt - BURST_WIDTH'(1);
                    r_to_cnt   <= '0;
                end else if (r_to_cnt != TO_W'(TIMEOUT)) begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end
        end
    end

    assign mem_rd_request      = (r_state == S_ISSUE) && (w_sel_len != '0);
    assign mem_rd_address      = w_sel_addr;
    assign mem_rd_burst_length = w_sel_len;

    // Return path is purely combinational so beats reach the owner with no added latency.
    assign vid_rd_available = mem_rd_available & w_xfer & ~r_grant_aux;
    assign aux_rd_available = mem_rd_available & w_xfer & r_grant_aux;
    assign vid_rd_data      = mem_rd_data;
    assign aux_rd_data      = mem_rd_data;

    assign busy        = w_busy;
    assign grant_aux   = r_grant_aux;
    assign overrun     = r_overrun;
    assign timeout     = r_timeout;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed bench for sdram_read_arbiter: a table of single-requester bursts plus
// hand-written sequences for arbitration order, overrun, timeout and reset.
module tb_sdram_read_arbiter;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam int BW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_rd_request, aux_rd_request;
    logic [AW-1:0] vid_rd_address, aux_rd_address;
    logic [BW-1:0] vid_rd_burst_length, aux_rd_burst_length;
    logic          vid_rd_available, aux_rd_available;
    logic [DW-1:0] vid_rd_data, aux_rd_data;
    logic          mem_rd_request;
    logic [AW-1:0] mem_rd_address;
    logic [BW-1:0] mem_rd_burst_length;
    logic          mem_rd_available;
    logic [DW-1:0] mem_rd_data;
    logic          busy, grant_aux, timeout;
    logic [1:0]    overrun;
    logic [1:0]    dbg_state;

    sdram_read_arbiter dut (
        .clk(clk), .reset(reset),
        .vid_rd_request(vid_rd_request), .vid_rd_address(vid_rd_address),
        .vid_rd_burst_length(vid_rd_burst_length), .vid_rd_available(vid_rd_available),
        .vid_rd_data(vid_rd_data),
        .aux_rd_request(aux_rd_request), .aux_rd_address(aux_rd_address),
        .aux_rd_burst_length(aux_rd_burst_length), .aux_rd_available(aux_rd_available),
        .aux_rd_data(aux_rd_data),
        .mem_rd_request(mem_rd_request), .mem_rd_address(mem_rd_address),
        .mem_rd_burst_length(mem_rd_burst_length), .mem_rd_available(mem_rd_available),
        .mem_rd_data(mem_rd_data),
        .busy(busy), .grant_aux(grant_aux), .overrun(overrun), .timeout(timeout),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int issue_cnt = 0, vid_beats = 0, aux_beats = 0;
    int ovr_vid_cnt = 0, ovr_aux_cnt = 0, to_cnt = 0;
    logic [DW-1:0] exp_vid_q[$];
    logic [DW-1:0] exp_aux_q[$];
    logic [DW-1:0] mon_exp;

    typedef struct {
        bit          is_aux;
        logic [AW-1:0] addr;
        logic [BW-1:0] len;
        bit          exp_issue;
        int          exp_vid_beats;
        int          exp_aux_beats;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every forwarded beat must match the next expected word for that owner.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rd_request) issue_cnt++;
            if (overrun[0]) ovr_vid_cnt++;
            if (overrun[1]) ovr_aux_cnt++;
            if (timeout) to_cnt++;
            if (vid_rd_available) begin
                vid_beats++;
                if (exp_vid_q.size() == 0) check("vid_unexpected_beat", 1, 0);
                else begin
                    mon_exp = exp_vid_q.pop_front();
                    check("vid_data", vid_rd_data, mon_exp);
                end
            end
            if (aux_rd_available) begin
                aux_beats++;
                if (exp_aux_q.size() == 0) check("aux_unexpected_beat", 1, 0);
                else begin
                    mon_exp = exp_aux_q.pop_front();
                    check("aux_data", aux_rd_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit v, input bit a,
                         input logic [AW-1:0] va, input logic [BW-1:0] vl,
                         input logic [AW-1:0] aa, input logic [BW-1:0] al);
        vid_rd_request      = v;
        vid_rd_address      = va;
        vid_rd_burst_length = vl;
        aux_rd_request      = a;
        aux_rd_address      = aa;
        aux_rd_burst_length = al;
        tick();
        vid_rd_request = 1'b0;
        aux_rd_request = 1'b0;
    endtask

    task automatic send_beats(input int n, input bit to_aux, input int max_gap);
        for (int i = 0; i < n; i++) begin
            mem_rd_available = 1'b1;
            mem_rd_data      = $urandom;
            if (to_aux) exp_aux_q.push_back(mem_rd_data);
            else        exp_vid_q.push_back(mem_rd_data);
            tick();
            mem_rd_available = 1'b0;
            if (max_gap > 0 && i < n - 1) repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    task automatic wait_req(input int budget, output int waited);
        waited = 0;
        while (!mem_rd_request && waited < budget) begin
            tick();
            waited++;
        end
        if (!mem_rd_request) waited = -1;
    endtask

    // exp_wait counts ticks after the cycle that follows the request pulse.
    task automatic expect_issue(input string tag, input logic [AW-1:0] a,
                                input logic [BW-1:0] l, input bit g, input int exp_wait);
        int w;
        wait_req(20, w);
        check({tag, "_wait"}, 64'(w), 64'(exp_wait));
        check({tag, "_addr"}, mem_rd_address, a);
        check({tag, "_len"}, mem_rd_burst_length, l);
        check({tag, "_grant"}, grant_aux, g);
        check({tag, "_busy"}, busy, 1);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, a0, i0, w;

        vecs[0] = '{1'b0, 23'h000100, 9'd80,  1'b1, 80, 0};
        vecs[1] = '{1'b1, 23'h004000, 9'd16,  1'b1, 0, 16};
        vecs[2] = '{1'b0, 23'h7FFFFF, 9'd1,   1'b1, 1, 0};
        vecs[3] = '{1'b1, 23'h000000, 9'd0,   1'b0, 0, 0};
        vecs[4] = '{1'b1, 23'h000001, 9'd511, 1'b1, 0, 511};
        vecs[5] = '{1'b0, 23'h123456, 9'd0,   1'b0, 0, 0};

        reset = 1'b1;
        vid_rd_request = 0; aux_rd_request = 0;
        vid_rd_address = '0; aux_rd_address = '0;
        vid_rd_burst_length = '0; aux_rd_burst_length = '0;
        mem_rd_available = 0; mem_rd_data = '0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_req", mem_rd_request, 0);
        check("rst_addr", mem_rd_address, 0);
        check("rst_len", mem_rd_burst_length, 0);
        check("rst_grant", grant_aux, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;
        tick();

        // Table: isolated bursts, including length 0 and the extreme lengths/addresses.
        for (int k = 0; k < 6; k++) begin
            v0 = vid_beats; a0 = aux_beats; i0 = issue_cnt;
            pulse(!vecs[k].is_aux, vecs[k].is_aux, vecs[k].addr, vecs[k].len,
                  vecs[k].addr, vecs[k].len);
            if (vecs[k].exp_issue) begin
                expect_issue($sformatf("vec%0d", k), vecs[k].addr, vecs[k].len,
                             vecs[k].is_aux, 1);
                send_beats(int'(vecs[k].len), vecs[k].is_aux, 2);
                check($sformatf("vec%0d_busy_after", k), busy, 0);
            end else begin
                repeat (4) tick();
                check($sformatf("vec%0d_no_req", k), 64'(issue_cnt - i0), 0);
                check($sformatf("vec%0d_idle", k), busy, 0);
            end
            check($sformatf("vec%0d_vid_beats", k), 64'(vid_beats - v0), 64'(vecs[k].exp_vid_beats));
            check($sformatf("vec%0d_aux_beats", k), 64'(aux_beats - a0), 64'(vecs[k].exp_aux_beats));
        end
        check("table_no_overrun", 64'(ovr_vid_cnt + ovr_aux_cnt), 0);

        // Simultaneous pulses: video wins, aux follows two cycles after video's last beat.
        pulse(1, 1, 23'h000200, 9'd80, 23'h004000, 9'd16);
        expect_issue("sim_vid", 23'h000200, 9'd80, 0, 1);
        send_beats(80, 0, 0);
        expect_issue("sim_aux", 23'h004000, 9'd16, 1, 1);
        a0 = aux_beats;
        send_beats(16, 1, 1);
        check("sim_aux_beats", 64'(aux_beats - a0), 16);

        // Aux in flight when video arrives: no preemption.
        pulse(0, 1, '0, '0, 23'h001000, 9'd40);
        expect_issue("nopre_aux", 23'h001000, 9'd40, 1, 1);
        send_beats(20, 1, 0);
        pulse(1, 0, 23'h000300, 9'd8, '0, '0);
        send_beats(20, 1, 0);
        expect_issue("nopre_vid", 23'h000300, 9'd8, 0, 1);
        send_beats(8, 0, 0);
        check("nopre_no_overrun", 64'(ovr_vid_cnt + ovr_aux_cnt), 0);

        // Overrun: second aux pulse 3 cycles later is dropped; video self-request dropped.
        i0 = issue_cnt;
        pulse(1, 0, 23'h000500, 9'd30, '0, '0);
        expect_issue("ovr_vid", 23'h000500, 9'd30, 0, 1);
        send_beats(5, 0, 0);
        pulse(0, 1, '0, '0, 23'h006000, 9'd4);
        check("ovr_first_ok", overrun, 2'b00);
        tick(); tick();
        pulse(0, 1, '0, '0, 23'h007000, 9'd9);
        check("ovr_aux_pulse", overrun, 2'b10);
        tick();
        check("ovr_aux_one_cycle", overrun, 2'b00);
        pulse(1, 0, 23'h000999, 9'd3, '0, '0);
        check("ovr_vid_pulse", overrun, 2'b01);
        send_beats(25, 0, 1);
        expect_issue("ovr_aux_issue", 23'h006000, 9'd4, 1, 1);
        send_beats(4, 1, 0);
        repeat (5) tick();
        check("ovr_issue_count", 64'(issue_cnt - i0), 2);

        // Timeout: 4 of 10 beats, then the SDRAM stalls.
        pulse(1, 0, 23'h000800, 9'd10, '0, '0);
        expect_issue("to_vid", 23'h000800, 9'd10, 0, 1);
        send_beats(4, 0, 0);
        w = 0;
        while (!timeout && w < 1100) begin
            tick();
            w++;
        end
        check("to_wait", 64'(w), 1023);
        check("to_busy", busy, 0);
        mem_rd_available = 1'b1;
        mem_rd_data      = 32'hDEADBEEF;
        check("to_late_vid", vid_rd_available, 0);
        check("to_late_aux", aux_rd_available, 0);
        tick();
        mem_rd_available = 1'b0;
        check("to_one_cycle", timeout, 0);
        check("to_count", 64'(to_cnt), 1);

        // Reset mid video burst with an aux request pending behind it.
        pulse(1, 0, 23'h000A00, 9'd20, '0, '0);
        expect_issue("rst_vid", 23'h000A00, 9'd20, 0, 1);
        send_beats(5, 0, 0);
        pulse(0, 1, '0, '0, 23'h000B00, 9'd6);
        reset = 1'b1;
        mem_rd_available = 1'b1;
        mem_rd_data = 32'h12345678;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_req", mem_rd_request, 0);
        check("midrst_grant", grant_aux, 0);
        check("midrst_vid_avail", vid_rd_available, 0);
        reset = 1'b0;
        tick();
        check("midrst_vid_avail2", vid_rd_available, 0);
        mem_rd_available = 1'b0;
        i0 = issue_cnt;
        repeat (5) tick();
        check("midrst_pending_lost", 64'(issue_cnt - i0), 0);

        check("vid_q_empty", 64'(exp_vid_q.size()), 0);
        check("aux_q_empty", 64'(exp_aux_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
